// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and timestamp words over Avalon-MM and compares them to build-time constants.
// Define SYSID_BOOT_CHECKER_RECHECK_EN to add periodic automatic rechecks while idle.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1462218947,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
    ,
    parameter int unsigned RECHECK_INTERVAL = 1000000
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout_err,
    output logic [31:0] read_id,
    output logic [31:0] read_ts,
    output logic [3:0]  retry_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        CHECK = 3'd5
    } state_t;

    state_t      state, state_d;
    logic [15:0] timer, timer_d;
    logic [3:0]  retry_d;
    logic        busy_d, done_d, pass_d, fail_d, tmo_d;
    logic [31:0] id_d, ts_d;
    logic        in_rw, accept, data_ok, timeout, match, start_any;

    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS);

    assign in_rw   = (state == RD_ID) || (state == WT_ID) || (state == RD_TS) || (state == WT_TS);
    assign accept  = avm_read && !avm_waitrequest;
    // Data only counts once our own read has been accepted; anything else is stray.
    assign data_ok = avm_readdatavalid && (accept || (state == WT_ID) || (state == WT_TS));
    assign timeout = in_rw && (timer == 16'(TIMEOUT_CYCLES));
    assign match   = (read_id == EXPECTED_ID) && (read_ts == EXPECTED_TS);

`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
    logic [31:0] idle_cnt;
    logic        auto_trig;

    assign auto_trig = (state == IDLE) && (pass || fail) && (idle_cnt == 32'(RECHECK_INTERVAL - 1));
    assign start_any = start || auto_trig;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= 32'd0;
        else if (state == IDLE && start_any)
            idle_cnt <= 32'd0;
        else if (state == IDLE && (pass || fail))
            idle_cnt <= idle_cnt + 32'd1;
    end
`else
    assign start_any = start;
`endif

    always_comb begin
        state_d = state;
        timer_d = in_rw ? timer + 16'd1 : 16'd0;
        retry_d = retry_cnt;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        fail_d  = fail;
        tmo_d   = timeout_err;
        id_d    = read_id;
        ts_d    = read_ts;

        case (state)
            IDLE: begin
                if (start_any) begin
                    state_d = RD_ID;
                    timer_d = 16'd0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    retry_d = 4'd0;
                end
            end
            RD_ID, WT_ID: begin
                if (data_ok) begin
                    id_d    = avm_readdata;
                    state_d = RD_TS;
                    timer_d = 16'd0;
                end else if (accept) begin
                    state_d = WT_ID;
                end
            end
            RD_TS, WT_TS: begin
                if (data_ok) begin
                    ts_d    = avm_readdata;
                    state_d = CHECK;
                end else if (accept) begin
                    state_d = WT_TS;
                end
            end
            CHECK: begin
                pass_d  = match;
                fail_d  = !match;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Data landing on the timeout cycle takes priority over the retry.
        if (timeout && !data_ok) begin
            timer_d = 16'd0;
            if (retry_cnt < 4'(MAX_RETRIES)) begin
                retry_d = retry_cnt + 4'd1;
                state_d = RD_ID;
            end else begin
                fail_d  = 1'b1;
                tmo_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= 16'd0;
            retry_cnt   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
            read_id     <= 32'd0;
            read_ts     <= 32'd0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            retry_cnt   <= retry_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timeout_err <= tmo_d;
            read_id     <= id_d;
            read_ts     <= ts_d;
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker with a configurable Avalon-MM slave model.
module tb_sysid_boot_checker;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy, done, pass, fail, timeout_err;
    logic [31:0] read_id, read_ts;
    logic [3:0]  retry_cnt;

    int vectors = 0;
    int miscompares = 0;

    // slave model configuration and observation
    int          ws = 0;
    int          lat = 0;
    bit          drop_id = 1'b0;
    logic [31:0] id_val = 32'd0;
    logic [31:0] ts_val = 32'd1462218947;
    int          reads = 0, stalls = 0, stall_bad = 0, done_seen = 0;
    int          wait_left = 0, pend = 0;
    logic [31:0] pend_data = 32'd0, rdata = 32'd0;
    bit          prev_stall = 1'b0;
    logic        stall_addr = 1'b0;

    sysid_boot_checker #(
        .TIMEOUT_CYCLES(8),
        .MAX_RETRIES(2)
`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
        , .RECHECK_INTERVAL(20)
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout_err(timeout_err),
        .read_id(read_id), .read_ts(read_ts), .retry_cnt(retry_cnt)
    );

    always #5 clock = ~clock;

    // Slave responds at the falling edge; the DUT samples at the next rising edge.
    initial begin
        forever begin
            @(negedge clock);
            if (done) done_seen++;
            avm_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = pend_data;
                end
            end
            if (avm_read) begin
                if (prev_stall && (avm_address !== stall_addr)) stall_bad++;
                if (wait_left > 0) begin
                    avm_waitrequest = 1'b1;
                    wait_left--;
                    stalls++;
                    prev_stall = 1'b1;
                    stall_addr = avm_address;
                end else begin
                    avm_waitrequest = 1'b0;
                    prev_stall = 1'b0;
                    reads++;
                    wait_left = ws;
                    rdata = avm_address ? ts_val : id_val;
                    if (!(drop_id && !avm_address)) begin
                        if (lat == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata = rdata;
                        end else begin
                            pend = lat;
                            pend_data = rdata;
                        end
                    end
                end
            end else begin
                if (prev_stall) stall_bad++;
                avm_waitrequest = 1'b0;
                prev_stall = 1'b0;
                wait_left = ws;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    // Returns n = negedges waited until done is seen (0 if already high).
    task automatic wait_done(input int max, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (!done && n < max) begin
            @(negedge clock);
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({busy, done, pass, fail, timeout_err, avm_read, avm_address, retry_cnt, read_id, read_ts} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fail=%b rd=%b want all 0", busy, done, pass, fail, avm_read);
            miscompares++;
        end
        @(negedge clock) reset_n = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || avm_read !== 1'b0) begin
            $display("FAIL reset_idle: got busy=%b read=%b want 0 0", busy, avm_read);
            miscompares++;
        end
    endtask

    task automatic test_pass();
        bit cyc_bad = 1'b0;
        pulse_start();
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL pass_busy: got busy=%b done=%b want 1 0", busy, done);
            miscompares++;
        end
        repeat (2) begin
            @(negedge clock);
            if (done !== 1'b0) cyc_bad = 1'b1;
        end
        @(negedge clock);
        vectors++;
        if (cyc_bad || done !== 1'b1) begin
            $display("FAIL pass_latency: got done=%b early=%b want done at cycle 4", done, cyc_bad);
            miscompares++;
        end
        vectors++;
        if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || retry_cnt !== 4'd0) begin
            $display("FAIL pass_flags: got pass=%b fail=%b busy=%b retry=%0d want 1 0 0 0", pass, fail, busy, retry_cnt);
            miscompares++;
        end
        vectors++;
        if (read_id !== 32'd0 || read_ts !== 32'd1462218947) begin
            $display("FAIL pass_data: got id=%h ts=%h want 00000000 %h", read_id, read_ts, 32'd1462218947);
            miscompares++;
        end
        @(negedge clock);
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL pass_done_pulse: got done=%b want 0", done);
            miscompares++;
        end
    endtask

    task automatic test_mismatch();
        bit ok; int n;
        ts_val = 32'h12345678;
        reads = 0;
        pulse_start();
        vectors++;
        if (pass !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL mis_clear: got pass=%b busy=%b want 0 1", pass, busy);
            miscompares++;
        end
        wait_done(20, ok, n);
        vectors++;
        if (!ok || fail !== 1'b1 || pass !== 1'b0 || timeout_err !== 1'b0) begin
            $display("FAIL mis_flags: got done=%b fail=%b pass=%b tmo=%b want 1 1 0 0", ok, fail, pass, timeout_err);
            miscompares++;
        end
        vectors++;
        if (read_ts !== 32'h12345678 || reads != 2) begin
            $display("FAIL mis_data: got ts=%h reads=%0d want 12345678 2", read_ts, reads);
            miscompares++;
        end
        ts_val = 32'd1462218947;
    endtask

    task automatic test_stall();
        bit ok; int n;
        ws = 3; lat = 2; stalls = 0; stall_bad = 0;
        pulse_start();
        wait_done(40, ok, n);
        vectors++;
        if (!ok || n != 13) begin
            $display("FAIL stall_latency: got done=%b at cycle %0d want cycle 14", ok, n + 1);
            miscompares++;
        end
        vectors++;
        if (pass !== 1'b1 || retry_cnt !== 4'd0) begin
            $display("FAIL stall_result: got pass=%b retry=%0d want 1 0", pass, retry_cnt);
            miscompares++;
        end
        vectors++;
        if (stalls != 6 || stall_bad != 0) begin
            $display("FAIL stall_hold: got stalls=%0d unstable=%0d want 6 0", stalls, stall_bad);
            miscompares++;
        end
        ws = 0; lat = 0;
    endtask

    task automatic test_timeout();
        bit ok; int n;
        drop_id = 1'b1; reads = 0; done_seen = 0;
        pulse_start();
        wait_done(100, ok, n);
        vectors++;
        if (!ok || n != 27) begin
            $display("FAIL tmo_latency: got done=%b at cycle %0d want cycle 28", ok, n + 1);
            miscompares++;
        end
        vectors++;
        if (fail !== 1'b1 || timeout_err !== 1'b1 || pass !== 1'b0 || retry_cnt !== 4'd2) begin
            $display("FAIL tmo_flags: got fail=%b tmo=%b pass=%b retry=%0d want 1 1 0 2", fail, timeout_err, pass, retry_cnt);
            miscompares++;
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (reads != 3 || done_seen != 1 || busy !== 1'b0) begin
            $display("FAIL tmo_attempts: got reads=%0d dones=%0d busy=%b want 3 1 0", reads, done_seen, busy);
            miscompares++;
        end
        drop_id = 1'b0;
    endtask

    task automatic test_timeout_edge();
        bit ok; int n;
        lat = 8; reads = 0;
        pulse_start();
        wait_done(60, ok, n);
        vectors++;
        if (!ok || pass !== 1'b1 || retry_cnt !== 4'd0 || reads != 2 || timeout_err !== 1'b0) begin
            $display("FAIL tmo_edge: got pass=%b retry=%0d reads=%0d tmo=%b want 1 0 2 0", pass, retry_cnt, reads, timeout_err);
            miscompares++;
        end
        lat = 0;
    endtask

    task automatic test_reset_mid();
        bit ok; int n;
        bit bad = 1'b0;
        lat = 5; reads = 0;
        pulse_start();
        n = 0;
        while (!(reads == 2 && !avm_read && busy) && n < 30) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (n >= 30) begin
            $display("FAIL rst_reach_wt_ts: got no WT_TS within %0d cycles want reached", n);
            miscompares++;
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, pass, fail, timeout_err, avm_read, avm_address, retry_cnt, read_id, read_ts} !== '0) begin
            $display("FAIL rst_async: got busy=%b rd=%b ts=%h want all 0", busy, avm_read, read_ts);
            miscompares++;
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (busy !== 1'b0 || avm_read !== 1'b0 || read_ts !== 32'd0) bad = 1'b1;
        end
        vectors++;
        if (bad || done_seen != 0) begin
            $display("FAIL rst_stray_rdv: got disturbed=%b dones=%0d want 0 0", bad, done_seen);
            miscompares++;
        end
        lat = 0;
        pulse_start();
        wait_done(20, ok, n);
        vectors++;
        if (!ok || pass !== 1'b1 || read_ts !== 32'd1462218947) begin
            $display("FAIL rst_fresh: got done=%b pass=%b ts=%h want 1 1 %h", ok, pass, read_ts, 32'd1462218947);
            miscompares++;
        end
    endtask

`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
    task automatic test_recheck();
        bit ok; int n;
        pulse_start();
        wait_done(20, ok, n);
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (n != 20) begin
            $display("FAIL recheck_interval: got busy after %0d idle cycles want 20", n);
            miscompares++;
        end
        wait_done(20, ok, n);
        reads = 0; done_seen = 0;
        repeat (19) @(negedge clock);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        wait_done(20, ok, n);
        repeat (10) @(negedge clock);
        vectors++;
        if (!ok || done_seen != 1 || reads != 2 || busy !== 1'b0) begin
            $display("FAIL recheck_merge: got dones=%0d reads=%0d busy=%b want 1 2 0", done_seen, reads, busy);
            miscompares++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_stall();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
`ifdef SYSID_BOOT_CHECKER_RECHECK_EN
        test_recheck();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
